// File: rtl/led_rate_counter.sv
// led_rate_counter: free-running LED binary counter whose step period is
// WAIT_TIME >> rate_shift clock cycles. Two active-low push-buttons are
// synchronised and debounced on chip; btn1 speeds up, btn2 slows down, and a
// two-button chord reverses the count direction.
//
// Ports
//   clk         system clock
//   rst_n       synchronous reset, active low
//   btn1        async, active low: speed up (rate_shift + 1, saturating)
//   btn2        async, active low: slow down (rate_shift - 1, saturating)
//   led         counter value, inverted when LED_ACTIVE_LOW = 1
//   tick        one-cycle pulse on each counter step
//   rate_shift  current speed exponent
//   dir_down    0: count up, 1: count down
module led_rate_counter #(
    parameter int unsigned WAIT_TIME       = 13500000,
    parameter int unsigned CNT_WIDTH       = 6,
    parameter int unsigned MAX_SHIFT       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter bit          LED_ACTIVE_LOW  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           btn1,
    input  logic                           btn2,
    output logic [CNT_WIDTH-1:0]           led,
    output logic                           tick,
    output logic [$clog2(MAX_SHIFT+1)-1:0] rate_shift,
    output logic                           dir_down
);

    localparam int unsigned SHIFT_W = $clog2(MAX_SHIFT + 1);
    localparam int unsigned TCNT_W  = $clog2(WAIT_TIME + 1);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned NUM_BTN = 2;

    // XOR mask that maps the count onto the LED pin polarity
    localparam logic [CNT_WIDTH-1:0] LED_MASK = {CNT_WIDTH{LED_ACTIVE_LOW}};

    // bit 0 = btn1 (speed up), bit 1 = btn2 (slow down)
    logic [NUM_BTN-1:0] pins;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] db;      // debounced level, 1 = released
    logic [NUM_BTN-1:0] press;   // one-cycle debounced 1->0 event
    logic [DB_W-1:0]    db_cnt [NUM_BTN];

    logic [TCNT_W-1:0]    tcnt;
    logic [CNT_WIDTH-1:0] count;

    logic                 chord;
    logic                 rate_chg;
    logic [SHIFT_W-1:0]   shift_nxt;
    logic                 dir_nxt;
    logic [TCNT_W-1:0]    period_m1;
    logic                 tick_nxt;
    logic [TCNT_W-1:0]    tcnt_nxt;
    logic [CNT_WIDTH-1:0] count_nxt;

    assign pins = {btn2, btn1};

    // Command decode, tick generation and next LED count
    always_comb begin
        chord     = 1'b0;
        rate_chg  = 1'b0;
        shift_nxt = rate_shift;
        dir_nxt   = dir_down;
        period_m1 = '0;
        tick_nxt  = 1'b0;
        tcnt_nxt  = '0;
        count_nxt = count;

        // An event while the other button is held down (including a
        // same-cycle double event) is a chord: reverse, keep the rate.
        chord = (press[0] && !db[1]) || (press[1] && !db[0]);

        if (chord) begin
            dir_nxt = ~dir_down;
        end else if (press[0] && (rate_shift < SHIFT_W'(MAX_SHIFT))) begin
            shift_nxt = rate_shift + SHIFT_W'(1);
            rate_chg  = 1'b1;
        end else if (press[1] && (rate_shift != '0)) begin
            shift_nxt = rate_shift - SHIFT_W'(1);
            rate_chg  = 1'b1;
        end

        period_m1 = TCNT_W'(WAIT_TIME >> rate_shift) - TCNT_W'(1);

        // A rate change restarts the period and swallows a coincident tick
        tick_nxt = !rate_chg && (tcnt == period_m1);
        tcnt_nxt = (rate_chg || tick_nxt) ? '0 : tcnt + TCNT_W'(1);

        // Step uses the current direction; a coincident toggle applies next time
        if (tick_nxt) begin
            count_nxt = dir_down ? count - CNT_WIDTH'(1) : count + CNT_WIDTH'(1);
        end
    end

    // Synchronisers, debouncers and all output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1      <= '1;
            sync2      <= '1;
            db         <= '1;
            press      <= '0;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                db_cnt[i] <= '0;
            end
            tcnt       <= '0;
            count      <= '0;
            tick       <= 1'b0;
            rate_shift <= '0;
            dir_down   <= 1'b0;
            led        <= LED_MASK;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                        // only the released->pressed transition is an event
                        press[i]  <= db[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
            tcnt       <= tcnt_nxt;
            count      <= count_nxt;
            tick       <= tick_nxt;
            rate_shift <= shift_nxt;
            dir_down   <= dir_nxt;
            led        <= count_nxt ^ LED_MASK;
        end
    end

endmodule

// File: tb/tb_led_rate_counter.sv
// Testbench for led_rate_counter: a behavioural model (delay line, run-length
// debounce, elapsed-cycle tick timer, integer LED count) is compared against the
// DUT every cycle, plus directed scenarios with hand-computed expectations and a
// randomized button/reset phase.
module tb_led_rate_counter;

    localparam int WAIT  = 16;
    localparam int CW    = 4;
    localparam int MAXS  = 3;
    localparam int DEB   = 4;
    localparam int MODC  = 1 << CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          b1;
    logic          b2;
    logic [CW-1:0] led;
    logic          tick;
    logic [1:0]    rate_shift;
    logic          dir_down;

    int checks   = 0;
    int failures = 0;

    led_rate_counter #(
        .WAIT_TIME      (WAIT),
        .CNT_WIDTH      (CW),
        .MAX_SHIFT      (MAXS),
        .DEBOUNCE_CYCLES(DEB),
        .LED_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn1      (b1),
        .btn2      (b2),
        .led       (led),
        .tick      (tick),
        .rate_shift(rate_shift),
        .dir_down  (dir_down)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_valid = 0;
    int m_count;
    bit m_dir;
    int m_shift;
    int m_elapsed;     // cycles since the period last restarted
    bit m_tick;
    bit m_level [2];   // accepted button level, 1 = released
    int m_run   [2];   // length of current disagreeing run
    bit m_event [2];   // press accepted on the previous edge
    bit m_delay [2][$];

    always @(posedge clk) begin : model
        bit pin [2];
        bit chord;
        bit changed;
        int nshift;
        bit ndir;
        int period;
        bit seen;
        pin[0] = b1;
        pin[1] = b2;
        if (!rst_n) begin
            m_valid   = 1;
            m_count   = 0;
            m_dir     = 0;
            m_shift   = 0;
            m_elapsed = 0;
            m_tick    = 0;
            for (int i = 0; i < 2; i++) begin
                m_level[i] = 1;
                m_run[i]   = 0;
                m_event[i] = 0;
                m_delay[i] = '{1'b1, 1'b1};
            end
        end else if (m_valid) begin
            chord   = (m_event[0] && !m_level[1]) || (m_event[1] && !m_level[0]);
            changed = 0;
            nshift  = m_shift;
            ndir    = m_dir;
            if (chord) ndir = !m_dir;
            else if (m_event[0] && m_shift < MAXS) begin nshift = m_shift + 1; changed = 1; end
            else if (m_event[1] && m_shift > 0)    begin nshift = m_shift - 1; changed = 1; end

            period = WAIT >> m_shift;
            if (changed) begin
                m_tick    = 0;
                m_elapsed = 0;
            end else if (m_elapsed + 1 == period) begin
                m_tick    = 1;
                m_elapsed = 0;
                m_count   = (m_count + (m_dir ? MODC - 1 : 1)) % MODC;
            end else begin
                m_tick    = 0;
                m_elapsed = m_elapsed + 1;
            end

            // pin value seen by the debouncer lags the pin by two edges
            for (int i = 0; i < 2; i++) begin
                seen = m_delay[i].pop_front();
                m_delay[i].push_back(pin[i]);
                m_event[i] = 0;
                if (seen != m_level[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_event[i] = m_level[i];
                        m_level[i] = seen;
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_shift = nshift;
            m_dir   = ndir;
        end
    end

    // ---------------- every-cycle comparison ----------------
    always @(negedge clk) begin
        logic [CW-1:0] exp_led;
        if (m_valid) begin
            exp_led = ~CW'(m_count);
            checks++;
            if (led !== exp_led || tick !== m_tick || int'(rate_shift) != m_shift ||
                dir_down !== m_dir) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t led=%h/%h tick=%b/%b rate=%0d/%0d dir=%b/%b (actual/required)",
                         $time, led, exp_led, tick, m_tick, rate_shift, m_shift, dir_down, m_dir);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // cycles until the next tick, bounded
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!tick && n < 200);
        if (!tick) chk("wait_tick_timeout", 0, 1);
    endtask

    // wait for a tick that leaves led at val, bounded
    task automatic wait_led(input int val);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!(tick && int'(led) == val) && n < 300);
        if (!(tick && int'(led) == val)) chk("wait_led_timeout", int'(led), val);
    endtask

    task automatic press(input int which, input int len);
        if (which == 1) b1 = 1'b0; else b2 = 1'b0;
        step(len);
        if (which == 1) b1 = 1'b1; else b2 = 1'b1;
        step(12);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        b1    = 1'b1;
        b2    = 1'b1;
        @(negedge clk);

        // 1: reset values, base period 16, first step F->E
        step(2);
        chk("rst_led", int'(led), 15);
        chk("rst_tick", int'(tick), 0);
        chk("rst_rate", int'(rate_shift), 0);
        chk("rst_dir", int'(dir_down), 0);
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_tick_cycles", n, 16);
        chk("first_tick_led", int'(led), 14);
        chk("model_first_count", m_count, 1);
        wait_tick(n);
        chk("base_period", n, 16);
        chk("second_tick_led", int'(led), 13);

        // 2: one long press -> rate 1 exactly 7 edges later; glitch ignored
        b1 = 1'b0;
        step(6);
        chk("latency_before", int'(rate_shift), 0);
        step(1);
        chk("latency_at", int'(rate_shift), 1);
        chk("model_rate_at", m_shift, 1);
        step(3);
        b1 = 1'b1;
        step(12);
        wait_tick(n);
        wait_tick(n);
        chk("period_shift1", n, 8);
        b1 = 1'b0;
        step(2);
        b1 = 1'b1;
        step(20);
        chk("glitch_ignored", int'(rate_shift), 1);

        // 3: saturation at MAX_SHIFT and at zero
        repeat (5) press(1, 10);
        chk("sat_max", int'(rate_shift), 3);
        wait_tick(n);
        wait_tick(n);
        chk("period_shift3", n, 2);
        do_reset();
        press(2, 10);
        chk("sat_zero", int'(rate_shift), 0);

        // 4: wrap up then chord and wrap down
        repeat (3) press(1, 10);
        wait_led(0);                 // count 15
        wait_tick(n);
        chk("wrap_up_led", int'(led), 15);
        b1 = 1'b0;
        b2 = 1'b0;
        step(10);
        chk("chord_dir", int'(dir_down), 1);
        chk("chord_rate", int'(rate_shift), 3);
        b1 = 1'b1;
        b2 = 1'b1;
        step(12);
        wait_led(15);                // count 0
        wait_tick(n);
        chk("wrap_down_led", int'(led), 0);

        // 5: hold btn2 (slows to 2), press btn1 -> chord; release btn2 no event
        b2 = 1'b0;
        step(12);
        chk("hold_b2_rate", int'(rate_shift), 2);
        b1 = 1'b0;
        step(10);
        chk("held_chord_dir", int'(dir_down), 0);
        chk("held_chord_rate", int'(rate_shift), 2);
        b1 = 1'b1;
        step(12);
        b2 = 1'b1;
        step(12);
        chk("release_no_dir", int'(dir_down), 0);
        chk("release_no_rate", int'(rate_shift), 2);

        // 6: reset mid-run at count 9, btn1 held through reset
        wait_led(6);                 // count 9
        chk("pre_reset_rate", int'(rate_shift), 2);
        rst_n = 1'b0;
        b1    = 1'b0;
        step(1);
        chk("mid_rst_led", int'(led), 15);
        chk("mid_rst_rate", int'(rate_shift), 0);
        chk("mid_rst_dir", int'(dir_down), 0);
        chk("mid_rst_tick", int'(tick), 0);
        rst_n = 1'b1;
        step(6);
        chk("held_rst_before", int'(rate_shift), 0);
        step(1);
        chk("held_rst_at", int'(rate_shift), 1);
        step(15);
        b1 = 1'b1;
        step(12);
        chk("held_rst_once", int'(rate_shift), 1);

        // randomized phase, checked every cycle against the model
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 10))
                0: begin
                    rst_n = 1'b0;
                    step($urandom_range(1, 2));
                    rst_n = 1'b1;
                end
                1, 2, 3: press(1, $urandom_range(1, 12));
                4, 5, 6: press(2, $urandom_range(1, 12));
                7: begin
                    b1 = 1'b0;
                    b2 = 1'b0;
                    step($urandom_range(1, 12));
                    b1 = 1'b1;
                    b2 = 1'b1;
                    step(12);
                end
                8: begin
                    b2 = 1'b0;
                    step($urandom_range(0, 10));
                    b1 = 1'b0;
                    step($urandom_range(1, 12));
                    b1 = 1'b1;
                    step($urandom_range(0, 6));
                    b2 = 1'b1;
                    step(12);
                end
                9: begin
                    for (int k = 0; k < 30; k++) begin
                        b1 = 1'($urandom_range(0, 1));
                        b2 = 1'($urandom_range(0, 1));
                        step(1);
                    end
                    b1 = 1'b1;
                    b2 = 1'b1;
                    step(12);
                end
                default: step($urandom_range(1, 40));
            endcase
            step($urandom_range(0, 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
